// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to APB3 bridge.
// The optional ACCESS-phase timeout is enabled with `define APB_TIMEOUT_EN.
package apb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WRESP,
        ST_RRESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int TMO_CNT_W      = 16;

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_rw_arb.sv
// IDLE-state read/write arbiter: a lone candidate wins, a conflict goes to the
// type not granted last (flag starts as "read", so the first conflict is a write).
module axi_lite_rw_arb
    import apb_bridge_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    input  logic wr_req,
    input  logic rd_req,
    output logic wr_grant,
    output logic rd_grant
);

    logic last_wr;

    always_comb begin
        wr_grant = idle && wr_req && (!rd_req || !last_wr);
        rd_grant = idle && rd_req && (!wr_req || last_wr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr <= 1'b0;
        end else if (wr_grant) begin
            last_wr <= 1'b1;
        end else if (rd_grant) begin
            last_wr <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_lite_apb_bridge.sv
// AXI4-Lite slave to APB3 master bridge, one transaction at a time.
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES.
module axi_lite_apb_bridge
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t                  state_q, state_d;
    logic                    psel_d, penable_d, pwrite_d, bvalid_d, rvalid_d;
    logic [ADDR_WIDTH-1:0]   paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_d, rdata_d;
    logic [1:0]              bresp_d, rresp_d;
    logic                    wr_grant, rd_grant, tmo_abort;

    // Gating idle with reset keeps every READY low while reset is held.
    axi_lite_rw_arb u_arb (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .idle     ((state_q == ST_IDLE) && PRESETn),
        .wr_req   (AWVALID && WVALID),
        .rd_req   (ARVALID),
        .wr_grant (wr_grant),
        .rd_grant (rd_grant)
    );

    assign AWREADY = wr_grant;
    assign WREADY  = wr_grant;
    assign ARREADY = rd_grant;

`ifdef APB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] tmo_q, tmo_d;
    assign tmo_abort = (state_q == ST_ACCESS) && !PREADY
                       && (tmo_q == TMO_CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_SETUP) begin
            tmo_d = '0;
        end else if (state_q == ST_ACCESS && !PREADY) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_abort = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        psel_d    = PSEL;
        penable_d = PENABLE;
        pwrite_d  = PWRITE;
        paddr_d   = PADDR;
        pwdata_d  = PWDATA;
        bvalid_d  = BVALID;
        bresp_d   = BRESP;
        rvalid_d  = RVALID;
        rresp_d   = RRESP;
        rdata_d   = RDATA;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_grant) begin
                    // Partial strobes are rejected without touching the APB bus.
                    if (&WSTRB) begin
                        state_d  = ST_SETUP;
                        psel_d   = 1'b1;
                        pwrite_d = 1'b1;
                        paddr_d  = AWADDR;
                        pwdata_d = WDATA;
                    end else begin
                        state_d  = ST_WRESP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_SLVERR;
                    end
                end else if (rd_grant) begin
                    state_d  = ST_SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = 1'b0;
                    paddr_d  = ARADDR;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (PREADY || tmo_abort) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (PWRITE) begin
                        state_d  = ST_WRESP;
                        bvalid_d = 1'b1;
                        bresp_d  = resp_of(PSLVERR || tmo_abort);
                    end else begin
                        state_d  = ST_RRESP;
                        rvalid_d = 1'b1;
                        rresp_d  = resp_of(PSLVERR || tmo_abort);
                        rdata_d  = tmo_abort ? '0 : PRDATA;
                    end
                end
            end
            ST_WRESP: begin
                if (BREADY) begin
                    state_d  = ST_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            ST_RRESP: begin
                if (RREADY) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
            RVALID  <= 1'b0;
            RRESP   <= RESP_OKAY;
            RDATA   <= '0;
        end else begin
            state_q <= state_d;
            PSEL    <= psel_d;
            PENABLE <= penable_d;
            PWRITE  <= pwrite_d;
            PADDR   <= paddr_d;
            PWDATA  <= pwdata_d;
            BVALID  <= bvalid_d;
            BRESP   <= bresp_d;
            RVALID  <= rvalid_d;
            RRESP   <= rresp_d;
            RDATA   <= rdata_d;
        end
    end

endmodule
